// File: rtl/display_pkg.sv
// Shared types and constants for the sequence player display.
package display_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_PLAY   = 2'd1,
    MODE_BLINK  = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    IDLE,
    SHOW,
    GAP,
    FIN,
    BLINK_ON,
    BLINK_OFF
  } state_t;

  localparam logic [7:0] SS_BLANK = 8'h00;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ssdec.sv
// Five-bit symbol to seven-segment decoder, segments {dp,g,f,e,d,c,b,a}, active high.
module ssdec
  import display_pkg::*;
(
  input  logic [4:0] sym_i,
  input  logic       en_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SS_BLANK;
    if (en_i) begin
      case (sym_i)
        5'd0:  seg_o = 8'h3F;
        5'd1:  seg_o = 8'h06;
        5'd2:  seg_o = 8'h5B;
        5'd3:  seg_o = 8'h4F;
        5'd4:  seg_o = 8'h66;
        5'd5:  seg_o = 8'h6D;
        5'd6:  seg_o = 8'h7D;
        5'd7:  seg_o = 8'h07;
        5'd8:  seg_o = 8'h7F;
        5'd9:  seg_o = 8'h6F;
        5'd10: seg_o = 8'h77;
        5'd11: seg_o = 8'h7C;
        5'd12: seg_o = 8'h39;
        5'd13: seg_o = 8'h5E;
        5'd14: seg_o = 8'h79;
        5'd15: seg_o = 8'h71;
        // letters and marks used by the game screens
        5'd16: seg_o = 8'h76;
        5'd17: seg_o = 8'h38;
        5'd18: seg_o = 8'h73;
        5'd19: seg_o = 8'h3E;
        5'd20: seg_o = 8'h50;
        5'd21: seg_o = 8'h54;
        5'd22: seg_o = 8'h5C;
        5'd23: seg_o = 8'h78;
        5'd24: seg_o = 8'h6E;
        5'd25: seg_o = 8'h40;
        5'd26: seg_o = 8'h08;
        5'd27: seg_o = 8'h1E;
        5'd28: seg_o = 8'h1C;
        5'd29: seg_o = 8'h58;
        5'd30: seg_o = 8'h74;
        5'd31: seg_o = 8'h80;
      endcase
    end
  end

endmodule

// File: rtl/seq_player_display.sv
// Registered seven-segment sequence display: static, timed cumulative play, and blink.
module seq_player_display
  import display_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 2,
  parameter int LEN_W     = $clog2(DIGITS + 1)
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [5*DIGITS-1:0]   seq,
  input  logic [LEN_W-1:0]      len,
  input  mode_t                 mode,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      step,
  output logic [8*DIGITS-1:0]   ss
);

  localparam int              CW       = $clog2(max_int(ON_TICKS, OFF_TICKS) + 1);
  localparam logic [CW-1:0]   ON_LAST  = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0]   OFF_LAST = (OFF_TICKS > 0) ? CW'(OFF_TICKS - 1) : '0;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DIGITS);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]      step_q, step_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [5*DIGITS-1:0]   seq_q, seq_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [8*DIGITS-1:0]   ss_q, ss_d;

  logic [LEN_W-1:0]      len_clamp;
  logic [LEN_W-1:0]      step_nxt;
  logic                  on_end, off_end, last_step, phase_end, timed;
  logic [DIGITS-1:0]     lit_d;
  logic [5*DIGITS-1:0]   dec_src;
  logic [8*DIGITS-1:0]   dec_seg;

  assign len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
  assign step_nxt  = step_q + LEN_W'(1);
  assign last_step = (step_nxt == len_q);
  assign on_end    = tick && (cnt_q == ON_LAST);
  assign off_end   = tick && (cnt_q == OFF_LAST);
  assign timed     = (state_q == SHOW) || (state_q == GAP) ||
                     (state_q == BLINK_ON) || (state_q == BLINK_OFF);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    seq_d     = seq_q;
    len_d     = len_q;
    phase_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (mode == MODE_BLINK) begin
          state_d = BLINK_ON;
        end else if (mode == MODE_PLAY && start) begin
          seq_d   = seq;
          len_d   = len_clamp;
          step_d  = '0;
          state_d = (len_clamp == '0) ? FIN : SHOW;
        end
      end
      SHOW: begin
        if (on_end) begin
          phase_end = 1'b1;
          if (OFF_TICKS > 0) begin
            state_d = GAP;
          end else if (last_step) begin
            state_d = FIN;
          end else begin
            step_d = step_nxt;
          end
        end
      end
      GAP: begin
        if (off_end) begin
          phase_end = 1'b1;
          if (last_step) begin
            state_d = FIN;
          end else begin
            state_d = SHOW;
            step_d  = step_nxt;
          end
        end
      end
      FIN: state_d = IDLE;
      BLINK_ON: begin
        if (mode != MODE_BLINK) begin
          state_d = IDLE;
        end else if (on_end) begin
          phase_end = 1'b1;
          if (OFF_TICKS > 0) state_d = BLINK_OFF;
        end
      end
      BLINK_OFF: begin
        if (mode != MODE_BLINK) begin
          state_d = IDLE;
        end else if (off_end) begin
          phase_end = 1'b1;
          state_d   = BLINK_ON;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!(state_d == SHOW || state_d == GAP)) step_d = '0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || phase_end) begin
      cnt_d = '0;
    end else if (tick && timed) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // An empty run spends one cycle busy before FIN so busy and done never overlap.
  always_comb begin
    busy_d = (state_d == SHOW) || (state_d == GAP) ||
             (state_d == FIN && state_q == IDLE);
    done_d = (state_d == FIN && state_q != IDLE) ||
             (state_q == FIN && !done_q);
  end

  always_comb begin
    lit_d = '0;
    for (int k = 0; k < DIGITS; k++) begin
      case (state_d)
        SHOW:     lit_d[k] = (LEN_W'(k) <= step_d);
        BLINK_ON: lit_d[k] = (LEN_W'(k) < len_clamp);
        IDLE:     lit_d[k] = (mode != MODE_PLAY) && (mode != MODE_BLINK) &&
                             (LEN_W'(k) < len_clamp);
        default:  lit_d[k] = 1'b0;
      endcase
    end
  end

  assign dec_src = (state_q == SHOW || state_q == GAP) ? seq_q : seq;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    ssdec u_ssdec (
      .sym_i (dec_src[5*k +: 5]),
      .en_i  (1'b1),
      .seg_o (dec_seg[8*k +: 8])
    );
  end

  always_comb begin
    ss_d = '0;
    for (int k = 0; k < DIGITS; k++) begin
      ss_d[8*k +: 8] = lit_d[k] ? dec_seg[8*k +: 8] : SS_BLANK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
      seq_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ss_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      len_q   <= len_d;
      seq_q   <= seq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ss_q    <= ss_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign step = step_q;
  assign ss   = ss_q;

endmodule

// File: tb/tb_seq_player_display.sv
// Randomized bench for seq_player_display against a phase-list reference model.
module tb_seq_player_display;
  import display_pkg::*;

  localparam int D   = 8;
  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int LW  = 4;

  localparam logic [7:0] SEG_TBL [32] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71,
    8'h76, 8'h38, 8'h73, 8'h3E, 8'h50, 8'h54, 8'h5C, 8'h78,
    8'h6E, 8'h40, 8'h08, 8'h1E, 8'h1C, 8'h58, 8'h74, 8'h80
  };

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           tick  = 1'b0;
  logic           start = 1'b0;
  logic [5*D-1:0] seq   = '0;
  logic [LW-1:0]  len   = '0;
  mode_t          mode  = MODE_STATIC;
  logic           busy, done;
  logic [LW-1:0]  step;
  logic [8*D-1:0] ss;

  seq_player_display #(
    .DIGITS(D), .ON_TICKS(ON), .OFF_TICKS(OFF), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .seq(seq), .len(len), .mode(mode),
    .start(start), .busy(busy), .done(done), .step(step), .ss(ss)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // tick generator
  int tick_per  = 3;
  bit tick_rand = 1'b1;
  int tick_ctr  = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (tick_rand) begin
        tick = ($urandom_range(0, tick_per - 1) == 0);
      end else begin
        tick     = (tick_ctr == 0);
        tick_ctr = (tick_ctr + 1) % tick_per;
      end
    end
  end

  // reference model: a run is a list of timed phases
  typedef struct {
    int lit;
    int stp;
    int ticks;
  } phase_t;

  phase_t         ph_q[$];
  int             ph_cnt;
  logic [5*D-1:0] run_seq;
  int             post;        // 1: cycle after done, 2: empty run about to signal done
  bit             in_blink, blink_on;
  int             blink_cnt;
  logic [69:0]    exp_q[$];

  function automatic int clampl(input int l);
    return (l > D) ? D : l;
  endfunction

  function automatic logic [63:0] lit_word(input logic [5*D-1:0] s, input int n);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < n && k < D; k++) w[8*k +: 8] = SEG_TBL[s[5*k +: 5]];
    return w;
  endfunction

  function automatic logic [63:0] idle_ss();
    if (mode == MODE_PLAY || mode == MODE_BLINK) return '0;
    return lit_word(seq, clampl(int'(len)));
  endfunction

  function automatic void model_reset();
    ph_q.delete();
    ph_cnt    = 0;
    post      = 0;
    in_blink  = 1'b0;
    blink_on  = 1'b0;
    blink_cnt = 0;
  endfunction

  function automatic logic [69:0] model_step();
    logic [63:0]   e_ss;
    logic          e_busy, e_done;
    logic [LW-1:0] e_step;
    int            l;
    e_ss = '0; e_busy = 1'b0; e_done = 1'b0; e_step = '0;
    if (ph_q.size() > 0) begin
      if (tick) ph_cnt++;
      if (ph_cnt == ph_q[0].ticks) begin
        void'(ph_q.pop_front());
        ph_cnt = 0;
      end
      if (ph_q.size() == 0) begin
        e_done = 1'b1;
        post   = 1;
      end else begin
        e_busy = 1'b1;
        e_step = LW'(ph_q[0].stp);
        e_ss   = lit_word(run_seq, ph_q[0].lit);
      end
    end else if (post != 0) begin
      e_done = (post == 2);
      post   = 0;
      e_ss   = idle_ss();
    end else if (in_blink) begin
      if (mode != MODE_BLINK) begin
        in_blink = 1'b0;
        e_ss     = idle_ss();
      end else begin
        if (tick) blink_cnt++;
        if (blink_on && blink_cnt == ON) begin
          blink_cnt = 0;
          blink_on  = (OFF == 0);
        end else if (!blink_on && blink_cnt == OFF) begin
          blink_cnt = 0;
          blink_on  = 1'b1;
        end
        e_ss = blink_on ? lit_word(seq, clampl(int'(len))) : '0;
      end
    end else if (mode == MODE_BLINK) begin
      in_blink  = 1'b1;
      blink_on  = 1'b1;
      blink_cnt = 0;
      e_ss      = lit_word(seq, clampl(int'(len)));
    end else if (mode == MODE_PLAY && start) begin
      l       = clampl(int'(len));
      run_seq = seq;
      ph_cnt  = 0;
      if (l == 0) begin
        e_busy = 1'b1;
        post   = 2;
      end else begin
        for (int s = 0; s < l; s++) begin
          ph_q.push_back('{lit: s + 1, stp: s, ticks: ON});
          if (OFF > 0) ph_q.push_back('{lit: 0, stp: s, ticks: OFF});
        end
        e_busy = 1'b1;
        e_ss   = lit_word(run_seq, 1);
      end
    end else begin
      e_ss = idle_ss();
    end
    return {e_busy, e_done, e_step, e_ss};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      exp_q.push_back(model_step());
    end
  end

  // scoreboard: every cycle the DUT outputs must match the model
  int          done_cnt = 0;
  int          max_step = 0;
  logic [69:0] e;
  always @(negedge clk) begin
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("sb_busy", 64'(busy), 64'(e[69]));
      check_eq("sb_done", 64'(done), 64'(e[68]));
      check_eq("sb_step", 64'(step), 64'(e[67:64]));
      check_eq("sb_ss",   ss,        e[63:0]);
    end
    if (done) done_cnt++;
    if (int'(step) > max_step) max_step = int'(step);
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_seq();
    for (int k = 0; k < D; k++) seq[5*k +: 5] = 5'($urandom_range(0, 31));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check_eq(tag, 64'(seen), 64'd1);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    exp_q.delete();
    exp_q.push_back('0);
    #1;
    check_eq("arst_ss",   ss,         64'd0);
    check_eq("arst_busy", 64'(busy),  64'd0);
    check_eq("arst_step", 64'(step),  64'd0);
    check_eq("arst_done", 64'(done),  64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    int seen;
    cyc(3);
    rst = 1'b0;
    check_eq("reset_ss",   ss,        64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_step", 64'(step), 64'd0);

    // static display of three symbols
    mode = MODE_STATIC;
    rand_seq();
    seq[14:0] = {5'd3, 5'd2, 5'd1};
    len = 4'd3;
    @(negedge clk);
    check_eq("static3_low",  64'(ss[23:0]),  64'h4F5B06);
    check_eq("static3_high", 64'(ss[63:24]), 64'd0);
    check_eq("static3_busy", 64'(busy),      64'd0);

    for (int i = 0; i < 10; i++) begin
      rand_seq();
      len  = 4'($urandom_range(0, 15));
      mode = (i % 3 == 2) ? mode_t'(2'd3) : MODE_STATIC;
      cyc(1);
    end

    // play len 3, tick every 10 cycles
    mode = MODE_PLAY;
    tick_rand = 1'b0;
    tick_per  = 10;
    rand_seq();
    len = 4'd3;
    cyc(2);
    done_cnt = 0;
    max_step = 0;
    pulse_start();
    wait_done("play3_done", 400);
    cyc(3);
    check_eq("play3_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("play3_max_step", 64'(max_step), 64'd2);
    check_eq("play3_busy_end", 64'(busy),     64'd0);

    // empty run
    tick_rand = 1'b1;
    tick_per  = 2;
    len = 4'd0;
    done_cnt = 0;
    pulse_start();
    check_eq("len0_busy_t1", 64'(busy), 64'd1);
    @(negedge clk);
    check_eq("len0_done_t2", 64'(done), 64'd1);
    check_eq("len0_busy_t2", 64'(busy), 64'd0);
    check_eq("len0_ss",      ss,        64'd0);
    cyc(3);
    check_eq("len0_done_cnt", 64'(done_cnt), 64'd1);

    // clamped play with a second start mid-run
    rand_seq();
    len = 4'd12;
    done_cnt = 0;
    max_step = 0;
    pulse_start();
    cyc(20);
    rand_seq();
    len = 4'd2;
    pulse_start();
    wait_done("clamp_done", 600);
    cyc(3);
    check_eq("clamp_max_step", 64'(max_step), 64'd7);
    check_eq("clamp_done_cnt", 64'(done_cnt), 64'd1);

    // static with clamped length lights all positions
    mode = MODE_STATIC;
    len  = 4'd12;
    cyc(2);
    nz = 0;
    for (int k = 0; k < D; k++) if (ss[8*k +: 8] != 8'h00) nz++;
    check_eq("static_clamp_lit", 64'(nz), 64'd8);

    // random play runs with junk inputs while busy
    for (int r = 0; r < 4; r++) begin
      mode     = MODE_PLAY;
      tick_per = $urandom_range(1, 3);
      rand_seq();
      len = 4'($urandom_range(0, 15));
      cyc(1);
      pulse_start();
      seen = 0;
      for (int i = 0; i < 800; i++) begin
        @(negedge clk);
        if (done) begin
          seen = 1;
          break;
        end
        rand_seq();
        len   = 4'($urandom_range(0, 15));
        start = ($urandom_range(0, 3) == 0);
        mode  = mode_t'(2'($urandom_range(0, 3)));
      end
      start = 1'b0;
      mode  = MODE_PLAY;
      check_eq("rand_run_done", 64'(seen), 64'd1);
      cyc(2);
    end

    // blink
    tick_per = 2;
    rand_seq();
    len  = 4'd8;
    mode = MODE_BLINK;
    cyc(40);
    len = 4'd5;
    cyc(20);
    mode = MODE_STATIC;
    cyc(2);
    check_eq("blink_to_static", ss, lit_word(seq, 5));
    cyc(3);

    // async reset during step 1, then a fresh run
    mode = MODE_PLAY;
    tick_per = 3;
    rand_seq();
    len = 4'd4;
    cyc(1);
    pulse_start();
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (step == 4'd1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("rst_wait_step1", 64'(seen), 64'd1);
    async_reset();
    cyc(1);
    done_cnt = 0;
    pulse_start();
    check_eq("restart_step", 64'(step),     64'd0);
    check_eq("restart_busy", 64'(busy),     64'd1);
    check_eq("restart_ss0",  64'(ss[7:0]),  64'(SEG_TBL[seq[4:0]]));
    check_eq("restart_rest", 64'(ss[63:8]), 64'd0);
    wait_done("restart_done", 400);
    cyc(3);
    check_eq("restart_done_cnt", 64'(done_cnt), 64'd1);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
